// File: rtl/boolean_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : boolean_alu_arbiter
// Description : Shares one combinational boolean_alu among NREQ requesters.
//               Round-robin arbitration over valid/ready command ports, one op
//               in flight, single response port tagged with the requester id.
//               ALU operand/select pins are driven from registers and alu_out
//               is captured into a response register.
// Ports       : clk, rst_n (sync, active low)
//               req_valid/req_ready [NREQ]      per-requester command handshake
//               req_in1/req_in2 [NREQ*W], req_sel [NREQ*SELW] packed commands
//               alu_in1/alu_in2 [W], alu_sel [SELW] -> boolean_alu
//               alu_out [W+1]                   <- boolean_alu
//               rsp_valid/rsp_ready, rsp_data [W+1], rsp_id [IDW]
//               op_count [16]   only when BALU_ARB_STATS_EN is defined
// Options     : BALU_ARB_STATS_EN - adds a wrapping completed-response counter
// Revision    : 1.0 - initial release
// ============================================================================
module boolean_alu_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int SELW = 3,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_in1,
    input  logic [NREQ*W-1:0]    req_in2,
    input  logic [NREQ*SELW-1:0] req_sel,
    output logic [W-1:0]         alu_in1,
    output logic [W-1:0]         alu_in2,
    output logic [SELW-1:0]      alu_sel,
    input  logic [W:0]           alu_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W:0]           rsp_data,
    output logic [IDW-1:0]       rsp_id
`ifdef BALU_ARB_STATS_EN
    ,
    output logic [15:0]          op_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_rr;
    logic [W-1:0]    r_alu_in1;
    logic [W-1:0]    r_alu_in2;
    logic [SELW-1:0] r_alu_sel;
    logic            r_rsp_valid;
    logic [W:0]      r_rsp_data;
    logic [IDW-1:0]  r_rsp_id;

    // Unpacked views of the packed per-requester command buses
    logic [W-1:0]    w_in1 [NREQ];
    logic [W-1:0]    w_in2 [NREQ];
    logic [SELW-1:0] w_sel [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_in1[gi] = req_in1[gi*W +: W];
        assign w_in2[gi] = req_in2[gi*W +: W];
        assign w_sel[gi] = req_sel[gi*SELW +: SELW];
    end

    // Valid vector widened to the full id space so any id-wide index is legal
    logic [(2**IDW)-1:0] w_valid_ext;
    assign w_valid_ext = (2**IDW)'(req_valid);

    logic           w_found;
    logic [IDW-1:0] w_winner;
    logic [IDW:0]   w_idx;

    // Scan from the round-robin pointer upward, wrapping at NREQ; first hit wins
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_rr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ)) begin
                w_idx = w_idx - (IDW+1)'(NREQ);
            end
            if (!w_found && w_valid_ext[w_idx[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[IDW-1:0];
            end
        end
    end

    // Grant is offered only in IDLE and never while reset is asserted; since
    // ready goes only to a valid requester, offering it is the handshake.
    logic            w_accept;
    logic [NREQ-1:0] w_onehot;
    logic [IDW-1:0]  w_rr_next;

    assign w_accept  = (r_state == S_IDLE) && rst_n && w_found;
    assign w_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
    assign req_ready = w_accept ? w_onehot : '0;
    assign w_rr_next = (w_winner == IDW'(NREQ-1)) ? '0 : w_winner + IDW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr        <= '0;
            r_alu_in1   <= '0;
            r_alu_in2   <= '0;
            r_alu_sel   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_in1 <= w_in1[w_winner];
                        r_alu_in2 <= w_in2[w_winner];
                        r_alu_sel <= w_sel[w_winner];
                        r_rsp_id  <= w_winner;
                        r_rr      <= w_rr_next;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // ALU inputs have been stable for a full cycle here
                    r_rsp_data  <= alu_out;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_in1   = r_alu_in1;
    assign alu_in2   = r_alu_in2;
    assign alu_sel   = r_alu_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

`ifdef BALU_ARB_STATS_EN
    logic [15:0] r_op_count;

    // Counts completed response handshakes; natural 16-bit wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (r_rsp_valid && rsp_ready) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_boolean_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_boolean_alu_arbiter
// Description : Directed self-checking bench for boolean_alu_arbiter. A
//               reference boolean ALU is modelled behaviourally on the alu_*
//               pins; expected responses are hand-computed constants.
//               ALU select map: 0 AND, 1 OR, 2 XOR, 3 NOT a, 4 ADD (carry in
//               bit W), 5 NAND, 6 NOR, 7 XNOR; logic ops zero-extend.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boolean_alu_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int SELW = 3;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W-1:0]    req_in1;
    logic [NREQ*W-1:0]    req_in2;
    logic [NREQ*SELW-1:0] req_sel;
    logic [W-1:0]         alu_in1;
    logic [W-1:0]         alu_in2;
    logic [SELW-1:0]      alu_sel;
    logic [W:0]           alu_out;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [W:0]           rsp_data;
    logic [IDW-1:0]       rsp_id;
`ifdef BALU_ARB_STATS_EN
    logic [15:0]          op_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    boolean_alu_arbiter #(.NREQ(NREQ), .W(W), .SELW(SELW), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_sel   (req_sel),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef BALU_ARB_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    function automatic logic [W:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [SELW-1:0] s);
        case (s)
            3'd0:    ref_alu = {1'b0, a & b};
            3'd1:    ref_alu = {1'b0, a | b};
            3'd2:    ref_alu = {1'b0, a ^ b};
            3'd3:    ref_alu = {1'b0, ~a};
            3'd4:    ref_alu = {1'b0, a} + {1'b0, b};
            3'd5:    ref_alu = {1'b0, ~(a & b)};
            3'd6:    ref_alu = {1'b0, ~(a | b)};
            default: ref_alu = {1'b0, ~(a ^ b)};
        endcase
    endfunction

    always_comb alu_out = ref_alu(alu_in1, alu_in2, alu_sel);

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [SELW-1:0] s);
        req_in1[i*W +: W]       = a;
        req_in2[i*W +: W]       = b;
        req_sel[i*SELW +: SELW] = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b1;
        set_req(0, 4'h1, 4'h2, 3'd1); set_req(1, 4'h3, 4'h4, 3'd2);
        set_req(2, 4'h5, 4'h6, 3'd3); set_req(3, 4'h7, 4'h8, 3'd4);
        repeat (2) @(posedge clk);
        step(); #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (alu_in1 !== 4'h0) begin n_fail++; $display("FAIL reset_alu_in1: got %h want 0", alu_in1); end
        n_checks++; if (alu_in2 !== 4'h0) begin n_fail++; $display("FAIL reset_alu_in2: got %h want 0", alu_in2); end
        n_checks++; if (alu_sel !== 3'd0) begin n_fail++; $display("FAIL reset_alu_sel: got %h want 0", alu_sel); end
        n_checks++; if (rsp_data !== 5'h00) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
        n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        rst_n = 1'b1; #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
        // Withdraw before the edge: no grant is taken, pointer stays at 0
        req_valid = 4'b0000;
        step(); #1;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_withdraw: got valid %b ready %b want 0 0000", rsp_valid, req_ready); end
    endtask

    task automatic test_single_op();
        step(); req_valid = 4'b0100; set_req(2, 4'b1010, 4'b0101, 3'b001); rsp_ready = 1'b1; #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        step(); req_valid = 4'b0000; #1;
        n_checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_exec: got ready %b valid %b want 0000 0", req_ready, rsp_valid); end
        n_checks++; if ({alu_in1, alu_in2, alu_sel} !== {4'b1010, 4'b0101, 3'b001}) begin n_fail++; $display("FAIL single_alu_pins: got %b %b %b want 1010 0101 001", alu_in1, alu_in2, alu_sel); end
        step(); #1;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
        n_checks++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_rsp_id: got %0d want 2", rsp_id); end
        n_checks++; if (rsp_data !== 5'h0F) begin n_fail++; $display("FAIL single_rsp_data: got %h want 0f", rsp_data); end
        step(); #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_drop: got %b want 0", rsp_valid); end
        // Second op exercises the carry bit of the ALU result
        step(); req_valid = 4'b0010; set_req(1, 4'b1111, 4'b0001, 3'd4); #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL add_ready: got %b want 0010", req_ready); end
        step(); req_valid = 4'b0000;
        step(); #1;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 5'h10) begin n_fail++; $display("FAIL add_rsp: got v%b id%0d d%h want v1 id1 d10", rsp_valid, rsp_id, rsp_data); end
        step();
    endtask

    task automatic test_round_robin();
        logic [W:0]  exp_data [4];
        logic [3:0]  exp_oh;
        int          e;
        exp_data[0] = 5'h0C; exp_data[1] = 5'h0A; exp_data[2] = 5'h06; exp_data[3] = 5'h03;
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1;
        set_req(0, 4'h3, 4'hF, 3'd2); set_req(1, 4'h5, 4'hF, 3'd2);
        set_req(2, 4'h9, 4'hF, 3'd2); set_req(3, 4'hC, 4'hF, 3'd2);
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            e = k % 4;
            exp_oh = 4'b0001 << e;
            #1;
            n_checks++; if (req_ready !== exp_oh) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_oh); end
            step(); #1;
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_exec_ready[%0d]: got %b want 0000", k, req_ready); end
            step(); #1;
            n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(e)) begin n_fail++; $display("FAIL rr_rsp_id[%0d]: got v%b id%0d want v1 id%0d", k, rsp_valid, rsp_id, e); end
            n_checks++; if (rsp_data !== exp_data[e]) begin n_fail++; $display("FAIL rr_rsp_data[%0d]: got %h want %h", k, rsp_data, exp_data[e]); end
            if (k == 4) req_valid = 4'b0000;
            step();
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0; req_valid = 4'b0001; set_req(0, 4'b1100, 4'b1010, 3'd0); #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_grant: got %b want 0001", req_ready); end
        step(); req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step(); #1;
            n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 5'h08 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL bp_hold[%0d]: got v%b d%h id%0d want v1 d08 id0", n, rsp_valid, rsp_data, rsp_id); end
            n_checks++; if (req_ready !== 4'b0000 || alu_in1 !== 4'b1100) begin n_fail++; $display("FAIL bp_ready[%0d]: got ready %b in1 %b want 0000 1100", n, req_ready, alu_in1); end
        end
        rsp_ready = 1'b1;
        step(); #1;
        n_checks++; if (req_ready !== 4'b0010 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got ready %b valid %b want 0010 0", req_ready, rsp_valid); end
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid_op();
        step(); req_valid = 4'b1000; set_req(3, 4'b0110, 4'b0011, 3'd5); #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL mid_grant: got %b want 1000", req_ready); end
        step(); req_valid = 4'b0000; rst_n = 1'b0; #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_exec_valid: got %b want 0", rsp_valid); end
        step(); #1;
        n_checks++; if (rsp_valid !== 1'b0 || alu_in1 !== 4'h0) begin n_fail++; $display("FAIL mid_after_reset: got v%b in1 %h want 0 0", rsp_valid, alu_in1); end
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step(); #1;
            n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp[%0d]: got %b want 0", n, rsp_valid); end
        end
        step(); req_valid = 4'b1111; #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_restart: got %b want 0001", req_ready); end
        req_valid = 4'b0000;
    endtask

`ifdef BALU_ARB_STATS_EN
    task automatic test_stats();
        step(); req_valid = 4'b1111; rsp_ready = 1'b1;
        repeat (14) step();
        req_valid = 4'b0000;
        step(); #1;
        n_checks++; if (op_count !== 16'd5) begin n_fail++; $display("FAIL stats_count: got %0d want 5", op_count); end
        force dut.r_op_count = 16'hFFFF;
        #1 release dut.r_op_count;
        step(); req_valid = 4'b0001;
        step(); req_valid = 4'b0000;
        step();
        step(); #1;
        n_checks++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL stats_wrap: got %h want 0000", op_count); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_in1 = '0; req_in2 = '0; req_sel = '0;
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
`ifdef BALU_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
